// File: rtl/des_core_arbiter.sv
// des_core_arbiter
//   Shares one DES core between two requesters. A block is accepted from one
//   requester at a time (round-robin, last-served loses ties), handed to the
//   core with a one-cycle start pulse, and the core's result (or a timeout
//   error) is held as a response until the consumer takes it.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   reqN_valid/data/ready     requester N plaintext handshake (N = 0, 1)
//   rsp_valid/id/data/err     response handshake with rsp_ready
//   core_plain/start          plaintext and start pulse to the DES core
//   core_cipher/valid         ciphertext and result pulse from the DES core
//   busy                      high whenever a block is in flight
module des_core_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [63:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [63:0] req1_data,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  input  logic        rsp_ready,
  output logic [63:0] core_plain,
  output logic        core_start,
  input  logic [63:0] core_cipher,
  input  logic        core_valid,
  output logic        busy
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          last_q;   // last-served requester
  logic          gid_q;    // requester owning the block in flight
  logic [63:0]   plain_q;
  logic [63:0]   data_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic          grant;
  logic          timeout_hit;
  logic          accept;

  // Tie goes to the requester that was not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready is gated by rst so no handshake can be reported on a reset edge.
  assign req0_ready = (state_q == IDLE) && !rst && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && !rst && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;

  // cnt_q holds the number of WAIT cycles already spent without a result,
  // so this is the last cycle in which core_valid is still accepted.
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (core_valid || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      plain_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            gid_q   <= req1_ready;
            plain_q <= req1_ready ? req1_data : req0_data;
          end
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          if (core_valid) begin
            data_q <= core_cipher;
            err_q  <= 1'b0;
          end else if (timeout_hit) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) last_q <= gid_q;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = gid_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;
  assign core_plain = plain_q;
  assign core_start = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);

endmodule
